// File: rtl/vfifo_replay_ctrl.sv
// Write/replay sequencer for the matrix-vector vector FIFO: counts write beats, replays each vector Repeats times.
// Optional saturating stall counters are enabled by defining VFIFO_REPLAY_CTRL_STATS_EN.
module vfifo_replay_ctrl #(
  parameter int unsigned VecElements      = 16,
  parameter int unsigned ElementsPerWrite = 4,
  parameter int unsigned ElementsPerRead  = 4,
  parameter int unsigned Depth            = 4,
  parameter int unsigned Repeats          = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_last_beat,
  output logic                       out_last_rep,
  output logic                       fifo_wr_en,
  output logic                       fifo_rd_en,
  output logic                       fifo_wrap_rd,
  output logic [$clog2(Depth+1)-1:0] vec_count
`ifdef VFIFO_REPLAY_CTRL_STATS_EN
  ,
  output logic [15:0]                in_stall_cnt,
  output logic [15:0]                out_stall_cnt
`endif
);

  localparam int unsigned WrBeats = VecElements / ElementsPerWrite;
  localparam int unsigned RdBeats = VecElements / ElementsPerRead;
  localparam int unsigned WbW     = (WrBeats > 1) ? $clog2(WrBeats) : 1;
  localparam int unsigned RbW     = (RdBeats > 1) ? $clog2(RdBeats) : 1;
  localparam int unsigned RpW     = (Repeats > 1) ? $clog2(Repeats) : 1;
  localparam int unsigned CntW    = $clog2(Depth + 1);
  localparam int unsigned Slots   = Depth * VecElements;

  if ((VecElements % ElementsPerWrite) != 0 || (VecElements % ElementsPerRead) != 0 ||
      (Slots & (Slots - 1)) != 0 || Repeats < 1) begin : g_bad_cfg
    $error("vfifo_replay_ctrl: invalid parameter combination");
  end

  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

  rd_state_t         state;
  logic [WbW-1:0]    wr_beat;
  logic [RbW-1:0]    rd_beat;
  logic [RpW-1:0]    rd_rep;
  logic              hs;
  logic              beat_last;
  logic              rep_last;
  logic              wr_done;
  logic              release_vec;
  logic [CntW-1:0]   vec_count_nxt;

  always_comb begin
    in_ready      = !rst_in && (wr_beat != '0 || vec_count < CntW'(Depth));
    fifo_wr_en    = in_valid && in_ready;
    out_valid     = !rst_in && (state == R_STREAM);
    beat_last     = (rd_beat == RbW'(RdBeats - 1));
    rep_last      = (rd_rep == RpW'(Repeats - 1));
    hs            = out_valid && out_ready;
    out_last_beat = out_valid && beat_last;
    out_last_rep  = out_valid && rep_last;
    // A last beat on a non-final pass rewinds the FIFO instead of popping.
    fifo_wrap_rd  = hs && beat_last && !rep_last;
    fifo_rd_en    = hs && !(beat_last && !rep_last);
    wr_done       = fifo_wr_en && (wr_beat == WbW'(WrBeats - 1));
    release_vec   = hs && beat_last && rep_last;
    vec_count_nxt = vec_count;
    if (wr_done && !release_vec) begin
      vec_count_nxt = vec_count + 1'b1;
    end else if (release_vec && !wr_done) begin
      vec_count_nxt = vec_count - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= R_IDLE;
      wr_beat   <= '0;
      rd_beat   <= '0;
      rd_rep    <= '0;
      vec_count <= '0;
    end else begin
      vec_count <= vec_count_nxt;
      if (fifo_wr_en) begin
        wr_beat <= wr_done ? '0 : wr_beat + 1'b1;
      end
      if (hs) begin
        rd_beat <= beat_last ? '0 : rd_beat + 1'b1;
        if (beat_last) begin
          rd_rep <= rep_last ? '0 : rd_rep + 1'b1;
        end
      end
      case (state)
        R_IDLE:   if (vec_count != '0) state <= R_STREAM;
        R_STREAM: if (release_vec && vec_count_nxt == '0) state <= R_IDLE;
      endcase
    end
  end

`ifdef VFIFO_REPLAY_CTRL_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && in_stall_cnt != '1) begin
        in_stall_cnt <= in_stall_cnt + 1'b1;
      end
      if (out_valid && !out_ready && out_stall_cnt != '1) begin
        out_stall_cnt <= out_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vfifo_replay_ctrl.sv
// Directed bench for vfifo_replay_ctrl: per-cycle model comparison plus hand-computed checkpoints.
module tb_vfifo_replay_ctrl;

  localparam int WrBeats = 4;
  localparam int RdBeats = 4;
  localparam int Depth   = 4;
  localparam int Repeats = 3;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       in_valid = 1'b1;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last_beat, out_last_rep;
  logic       fifo_wr_en, fifo_rd_en, fifo_wrap_rd;
  logic [2:0] vec_count;
`ifdef VFIFO_REPLAY_CTRL_STATS_EN
  logic [15:0] in_stall_cnt, out_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vfifo_replay_ctrl #(
    .VecElements(16), .ElementsPerWrite(4), .ElementsPerRead(4), .Depth(4), .Repeats(3)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_last_beat(out_last_beat),
    .out_last_rep(out_last_rep), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_wrap_rd(fifo_wrap_rd), .vec_count(vec_count)
`ifdef VFIFO_REPLAY_CTRL_STATS_EN
    , .in_stall_cnt(in_stall_cnt), .out_stall_cnt(out_stall_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: vectors held, write beats of the open vector, flat replay position of the head vector.
  int m_vecs = 0, m_wr = 0, m_pos = 0, m_next_vecs = 0;
  bit m_active = 0, m_init = 0;
  bit e_rdy, e_val, e_hs, e_wrap, e_rd, e_lb, e_lr, e_wdone, e_rel;

  always @(negedge clk_in) begin
    e_rdy   = !rst_in && (m_wr != 0 || m_vecs < Depth);
    e_val   = !rst_in && m_active;
    e_hs    = e_val && out_ready;
    e_lb    = e_val && (m_pos % RdBeats) == RdBeats - 1;
    e_lr    = e_val && (m_pos / RdBeats) == Repeats - 1;
    e_wrap  = e_hs && (m_pos % RdBeats) == RdBeats - 1 && (m_pos / RdBeats) < Repeats - 1;
    e_rel   = e_hs && m_pos == RdBeats * Repeats - 1;
    e_rd    = e_hs && !e_wrap;
    e_wdone = in_valid && e_rdy && m_wr == WrBeats - 1;
    if (m_init) begin
      chk("in_ready", in_ready, e_rdy);
      chk("fifo_wr_en", fifo_wr_en, in_valid && e_rdy);
      chk("out_valid", out_valid, e_val);
      chk("out_last_beat", out_last_beat, e_lb);
      chk("out_last_rep", out_last_rep, e_lr);
      chk("fifo_rd_en", fifo_rd_en, e_rd);
      chk("fifo_wrap_rd", fifo_wrap_rd, e_wrap);
      chk("vec_count", vec_count, m_vecs);
    end
    if (rst_in) begin
      m_vecs = 0; m_wr = 0; m_pos = 0; m_active = 0; m_init = 1;
    end else if (m_init) begin
      if (in_valid && e_rdy) m_wr = (m_wr + 1) % WrBeats;
      if (e_hs) m_pos = (m_pos + 1) % (RdBeats * Repeats);
      m_next_vecs = m_vecs + int'(e_wdone) - int'(e_rel);
      m_active = m_active ? !(e_rel && m_next_vecs == 0) : (m_vecs > 0);
      m_vecs = m_next_vecs;
    end
  end

  task automatic cyc(input logic v, input logic r, input logic rs);
    @(posedge clk_in);
    #1;
    in_valid = v; out_ready = r; rst_in = rs;
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 8) begin
      cyc(0, 0, 0);
      n++;
    end
    chk(name, out_valid, 1);
  endtask

  int wr_cnt;
  logic [11:0] rd_seq, wrap_seq, lr_seq;
  logic [3:0] rd4, wrap4;

  initial begin
    // Reset with in_valid high
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_rd_wrap", {fifo_rd_en, fifo_wrap_rd, out_valid}, 0);
    cyc(0, 0, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // One vector, consumer stalled
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      wr_cnt += int'(fifo_wr_en);
    end
    cyc(0, 0, 0);
    wr_cnt += int'(fifo_wr_en);
    chk("count_after_vec", vec_count, 1);
    chk("valid_not_yet", out_valid, 0);
    cyc(0, 0, 0);
    chk("valid_latency", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      wr_cnt += int'(fifo_wr_en);
      chk("valid_hold", out_valid, 1);
    end
    chk("wr_en_cycles", wr_cnt, 4);

    // Replay 3 times
    rd_seq = '0; wrap_seq = '0; lr_seq = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0);
      rd_seq = {rd_seq[10:0], fifo_rd_en};
      wrap_seq = {wrap_seq[10:0], fifo_wrap_rd};
      lr_seq = {lr_seq[10:0], out_last_rep};
    end
    chk("rd_en_pattern", rd_seq, 12'b1110_1110_1111);
    chk("wrap_pattern", wrap_seq, 12'b0001_0001_0000);
    chk("last_rep_pattern", lr_seq, 12'b0000_0000_1111);
    cyc(0, 0, 0);
    chk("freed_count", vec_count, 0);
    chk("freed_valid", out_valid, 0);

    // Fill to Depth
    wr_cnt = 0;
    for (int i = 1; i <= 21; i++) begin
      cyc(1, 0, 0);
      wr_cnt += int'(fifo_wr_en);
      chk("fill_in_ready", in_ready, (i <= 16) ? 1 : 0);
    end
    cyc(0, 0, 0);
    chk("fill_wr_cycles", wr_cnt, 16);
    chk("full_count", vec_count, 4);
`ifdef VFIFO_REPLAY_CTRL_STATS_EN
    chk("in_stall_cnt", in_stall_cnt, 5);
`endif

    // Full FIFO with continuous traffic both sides
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 1, 0);
      chk("full_in_ready", in_ready, 0);
    end
    cyc(1, 1, 0);
    chk("ready_after_release", in_ready, 1);
    chk("count_after_release", vec_count, 3);
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, 0);
      chk("steady_count_range", (vec_count == 3 || vec_count == 4) ? 1 : 0, 1);
    end

    // Reset in the middle of a replay
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    wait_valid("first_valid_timeout");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("midrst_strobes", {out_valid, fifo_rd_en, fifo_wrap_rd}, 0);
    cyc(0, 1, 0);
    chk("after_rst_valid", out_valid, 0);
    chk("after_rst_count", vec_count, 0);
    chk("after_rst_strobes", {fifo_rd_en, fifo_wrap_rd}, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    wait_valid("fresh_valid_timeout");
    rd4 = '0; wrap4 = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      if (i == 0) chk("fresh_rep0", out_last_rep, 0);
      rd4 = {rd4[2:0], fifo_rd_en};
      wrap4 = {wrap4[2:0], fifo_wrap_rd};
    end
    chk("fresh_rd_pattern", rd4, 4'b1110);
    chk("fresh_wrap_pattern", wrap4, 4'b0001);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("fresh_freed", vec_count, 0);
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
